// File: rtl/alu_seq_responder_if.sv
// Request/response handshake bundle for the sequential ALU responder.
interface alu_seq_responder_if #(
  parameter int nIO = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic signed [nIO-1:0] A;
  logic signed [nIO-1:0] B;
  logic [2:0]            OP;
  logic                  resp_valid;
  logic                  resp_ready;
  logic signed [nIO-1:0] Z;
  logic                  OV;

  modport master (
    output req_valid, A, B, OP, resp_ready,
    input  req_ready, resp_valid, Z, OV
  );

  modport slave (
    input  req_valid, A, B, OP, resp_ready,
    output req_ready, resp_valid, Z, OV
  );
endinterface

// File: rtl/alu_seq_responder.sv
// Handshaked registered ALU, one request in flight; result carries a signed-overflow flag.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add signed multiply for OP=111.
module alu_seq_responder #(
  parameter int nIO = 8
) (
  input logic               clk,
  input logic               rst_n,
  alu_seq_responder_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MAX = 3'b010;
  localparam logic [2:0] OP_MIN = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t state, state_nxt;
  logic   accept;
  logic   is_mul;
  logic   mul_last;
  logic signed [nIO-1:0] z_p1;
  logic                  ov_p1;

  // Single-cycle ops; an unknown/unsupported opcode reports Z=0, OV=1.
  function automatic logic [nIO:0] alu_eval(input logic signed [nIO-1:0] a,
                                            input logic signed [nIO-1:0] b,
                                            input logic [2:0] op);
    logic signed [nIO-1:0] r;
    logic                  ov;
    r  = '0;
    ov = 1'b0;
    case (op)
      OP_ADD: begin
        r  = a + b;
        ov = (a[nIO-1] == b[nIO-1]) && (r[nIO-1] != a[nIO-1]);
      end
      OP_SUB: begin
        r  = a - b;
        ov = (a[nIO-1] != b[nIO-1]) && (r[nIO-1] != a[nIO-1]);
      end
      OP_MAX:  r = (a >= b) ? a : b;
      OP_MIN:  r = (a <= b) ? a : b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: ov = 1'b1;
    endcase
    return {ov, r};
  endfunction

  assign bus.req_ready  = (state == IDLE) || (state == DONE && bus.resp_ready);
  assign bus.resp_valid = (state == DONE);
  assign bus.Z          = z_p1;
  assign bus.OV         = ov_p1;
  assign accept         = bus.req_valid && bus.req_ready;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(nIO);

  logic [2*nIO-1:0]        acc_p, ma_p, acc_nxt;
  logic signed [2*nIO-1:0] prod;
  logic [nIO:0]            mb_p;
  logic                    neg_p;
  logic [CW-1:0]           cnt_p;

  // nIO+1 bits so that the magnitude of the most negative value is representable.
  function automatic logic [nIO:0] mag(input logic signed [nIO-1:0] v);
    logic [nIO:0] e;
    e = {v[nIO-1], v};
    return e[nIO] ? (~e + 1'b1) : e;
  endfunction

  function automatic logic mul_ovf(input logic signed [2*nIO-1:0] p);
    return !((&p[2*nIO-1:nIO-1]) || !(|p[2*nIO-1:nIO-1]));
  endfunction

  assign is_mul   = (bus.OP == 3'b111);
  assign mul_last = (state == MULT) && (cnt_p == CW'(nIO - 1));
  assign acc_nxt  = acc_p + (mb_p[0] ? ma_p : '0);
  assign prod     = neg_p ? -$signed(acc_nxt) : $signed(acc_nxt);

  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      acc_p <= '0;
      ma_p  <= {{(nIO-1){1'b0}}, mag(bus.A)};
      mb_p  <= mag(bus.B);
      neg_p <= bus.A[nIO-1] ^ bus.B[nIO-1];
    end else if (state == MULT) begin
      acc_p <= acc_nxt;
      ma_p  <= ma_p << 1;
      mb_p  <= mb_p >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_p <= '0;
    else if (accept && is_mul) cnt_p <= '0;
    else if (state == MULT)    cnt_p <= cnt_p + 1'b1;
  end
`else
  assign is_mul   = 1'b0;
  assign mul_last = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_mul ? state_t'(2'd1) : DONE;
`ifdef ALU_SEQ_MUL_EN
      MULT: if (mul_last) state_nxt = DONE;
`endif
      DONE: begin
        if (accept)              state_nxt = is_mul ? state_t'(2'd1) : DONE;
        else if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result register: loaded on accept for 1-cycle ops, or on the final multiply step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_p1  <= '0;
      ov_p1 <= 1'b0;
    end else if (accept && !is_mul) begin
      {ov_p1, z_p1} <= alu_eval(bus.A, bus.B, bus.OP);
`ifdef ALU_SEQ_MUL_EN
    end else if (mul_last) begin
      z_p1  <= prod[nIO-1:0];
      ov_p1 <= mul_ovf(prod);
`endif
    end
  end

endmodule
